// File: rtl/rx_block_lock.sv
`default_nettype none
// ============================================================================
// Module      : rx_block_lock
// Description : 66b block-lock state machine for a 32-bit receive path.
//               It samples each qualified 2-bit sync header from the Rx
//               gearbox. Until it finds alignment, it sends single-cycle slip
//               requests back to the gearbox. It publishes block-lock status
//               so that downstream stages can qualify decoding.
//
//               Optional feature (macro RX_BLOCK_LOCK_HIBER_EN): a hi-BER
//               monitor that counts invalid headers inside a fixed timer
//               window while locked. When the macro is undefined, o_hi_ber
//               is tied to 0 and no monitor logic is built.
//
// Ports       : i_rxc             - receive clock, the only clock
//               i_reset_n         - asynchronous active-low reset
//               i_init_done       - transceiver initialisation complete
//               i_rx_header[1:0]  - sync header from the gearbox
//               i_rx_data_valid   - gearbox word valid
//               i_rx_header_valid - i_rx_header is meaningful this word
//               o_block_lock      - block lock achieved
//               o_slip            - one-cycle request to slip by one bit
//               o_hi_ber          - high bit-error-rate flag
//
// Revision    : 1.0 - initial release
// ============================================================================
module rx_block_lock #(
  parameter int unsigned SH_CNT_MAX         = 64,
  parameter int unsigned SH_INVALID_MAX     = 16,
  parameter int unsigned SLIP_WAIT          = 32,
  parameter int unsigned HIBER_TIMER_CYCLES = 40283,
  parameter int unsigned HIBER_THRESH       = 16
) (
  input  logic       i_rxc,
  input  logic       i_reset_n,
  input  logic       i_init_done,
  input  logic [1:0] i_rx_header,
  input  logic       i_rx_data_valid,
  input  logic       i_rx_header_valid,
  output logic       o_block_lock,
  output logic       o_slip,
  output logic       o_hi_ber
);

  localparam int unsigned SH_CNT_W   = $clog2(SH_CNT_MAX + 1);
  localparam int unsigned INV_CNT_W  = $clog2(SH_INVALID_MAX + 1);
  localparam int unsigned SLIP_CNT_W = $clog2(SLIP_WAIT + 1);

  localparam logic [SH_CNT_W-1:0]   C_SH_CNT_MAX     = SH_CNT_W'(SH_CNT_MAX);
  localparam logic [INV_CNT_W-1:0]  C_SH_INVALID_MAX = INV_CNT_W'(SH_INVALID_MAX);
  localparam logic [SLIP_CNT_W-1:0] C_SLIP_WAIT      = SLIP_CNT_W'(SLIP_WAIT);

  typedef enum logic [1:0] {
    ST_INIT      = 2'd0,
    ST_TEST      = 2'd1,
    ST_SLIP      = 2'd2,
    ST_SLIP_WAIT = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic                  block_lock_q, block_lock_d;
  logic                  slip_q, slip_d;
  logic [SH_CNT_W-1:0]   sh_cnt_q, sh_cnt_d;
  logic [INV_CNT_W-1:0]  sh_invalid_cnt_q, sh_invalid_cnt_d;
  logic [SLIP_CNT_W-1:0] slip_cnt_q, slip_cnt_d;

  logic                  w_qual;
  logic                  w_sh_valid;
  logic [SH_CNT_W-1:0]   w_sh_cnt_inc;
  logic [INV_CNT_W-1:0]  w_inv_cnt_inc;
  logic [SLIP_CNT_W-1:0] w_slip_cnt_inc;

  assign w_qual     = i_rx_data_valid & i_rx_header_valid;
  assign w_sh_valid = (i_rx_header == 2'b01) || (i_rx_header == 2'b10);

  // Post-increment values. The decision logic in TEST compares against
  // these, so a threshold takes effect in the same cycle as the header that
  // reaches it. None of the counters can wrap: each one is cleared at its
  // terminal value before another increment can happen.
  assign w_sh_cnt_inc   = sh_cnt_q + SH_CNT_W'(1);
  assign w_inv_cnt_inc  = sh_invalid_cnt_q + INV_CNT_W'(!w_sh_valid);
  assign w_slip_cnt_inc = slip_cnt_q + SLIP_CNT_W'(1);

  always_ff @(posedge i_rxc or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q          <= ST_INIT;
      block_lock_q     <= 1'b0;
      slip_q           <= 1'b0;
      sh_cnt_q         <= '0;
      sh_invalid_cnt_q <= '0;
      slip_cnt_q       <= '0;
    end else begin
      state_q          <= state_d;
      block_lock_q     <= block_lock_d;
      slip_q           <= slip_d;
      sh_cnt_q         <= sh_cnt_d;
      sh_invalid_cnt_q <= sh_invalid_cnt_d;
      slip_cnt_q       <= slip_cnt_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    block_lock_d     = block_lock_q;
    slip_d           = 1'b0;
    sh_cnt_d         = sh_cnt_q;
    sh_invalid_cnt_d = sh_invalid_cnt_q;
    slip_cnt_d       = slip_cnt_q;

    if (!i_init_done) begin
      // Losing initialisation overrides every state. No slip is issued.
      state_d          = ST_INIT;
      block_lock_d     = 1'b0;
      sh_cnt_d         = '0;
      sh_invalid_cnt_d = '0;
      slip_cnt_d       = '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          block_lock_d     = 1'b0;
          sh_cnt_d         = '0;
          sh_invalid_cnt_d = '0;
          slip_cnt_d       = '0;
          state_d          = ST_TEST;
        end

        ST_TEST: begin
          if (w_qual) begin
            sh_cnt_d         = w_sh_cnt_inc;
            sh_invalid_cnt_d = w_inv_cnt_inc;
            if (!w_sh_valid && !block_lock_q) begin
              state_d = ST_SLIP;
            end else if (!w_sh_valid && (w_inv_cnt_inc == C_SH_INVALID_MAX)) begin
              state_d = ST_SLIP;
            end else if (w_sh_cnt_inc == C_SH_CNT_MAX) begin
              // This point is reached unlocked only if the whole window
              // was clean, because any unlocked error slips immediately.
              // Reached locked, the error count is below the limit.
              if (w_inv_cnt_inc == '0) begin
                block_lock_d = 1'b1;
              end
              sh_cnt_d         = '0;
              sh_invalid_cnt_d = '0;
            end
          end
        end

        ST_SLIP: begin
          // Any header arriving in this cycle is dropped on purpose. The
          // slip itself is registered and appears on the next cycle.
          slip_d           = 1'b1;
          block_lock_d     = 1'b0;
          sh_cnt_d         = '0;
          sh_invalid_cnt_d = '0;
          slip_cnt_d       = '0;
          state_d          = ST_SLIP_WAIT;
        end

        ST_SLIP_WAIT: begin
          if (w_qual) begin
            if (w_slip_cnt_inc == C_SLIP_WAIT) begin
              slip_cnt_d = '0;
              state_d    = ST_TEST;
            end else begin
              slip_cnt_d = w_slip_cnt_inc;
            end
          end
        end

        default: begin
          state_d = ST_INIT;
        end
      endcase
    end
  end

  assign o_block_lock = block_lock_q;
  assign o_slip       = slip_q;

`ifdef RX_BLOCK_LOCK_HIBER_EN
  localparam int unsigned TIMER_W   = $clog2(HIBER_TIMER_CYCLES + 1);
  localparam int unsigned BER_CNT_W = $clog2(HIBER_THRESH + 1);

  localparam logic [TIMER_W-1:0]   C_TIMER_LAST   = TIMER_W'(HIBER_TIMER_CYCLES - 1);
  localparam logic [BER_CNT_W-1:0] C_HIBER_THRESH = BER_CNT_W'(HIBER_THRESH);

  logic [TIMER_W-1:0]   ber_timer_q, ber_timer_d;
  logic [BER_CNT_W-1:0] ber_cnt_q, ber_cnt_d;
  logic                 hi_ber_q, hi_ber_d;
  logic [BER_CNT_W-1:0] w_ber_cnt_inc;

  // The count saturates at the threshold, so a very noisy window cannot wrap
  // it back below the threshold before the timer expires.
  assign w_ber_cnt_inc = ber_cnt_q +
                         BER_CNT_W'(w_qual && !w_sh_valid && (ber_cnt_q != C_HIBER_THRESH));

  always_ff @(posedge i_rxc or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ber_timer_q <= '0;
      ber_cnt_q   <= '0;
      hi_ber_q    <= 1'b1;
    end else begin
      ber_timer_q <= ber_timer_d;
      ber_cnt_q   <= ber_cnt_d;
      hi_ber_q    <= hi_ber_d;
    end
  end

  always_comb begin
    ber_timer_d = ber_timer_q;
    ber_cnt_d   = ber_cnt_q;
    hi_ber_d    = hi_ber_q;

    if (!block_lock_q) begin
      ber_timer_d = '0;
      ber_cnt_d   = '0;
      hi_ber_d    = 1'b1;
    end else if (ber_timer_q == C_TIMER_LAST) begin
      // At window end, the flag clears only if the final count, including
      // this cycle's header, stayed below the threshold.
      if (w_ber_cnt_inc != C_HIBER_THRESH) begin
        hi_ber_d = 1'b0;
      end else begin
        hi_ber_d = 1'b1;
      end
      ber_timer_d = '0;
      ber_cnt_d   = '0;
    end else begin
      ber_timer_d = ber_timer_q + TIMER_W'(1);
      ber_cnt_d   = w_ber_cnt_inc;
      if (w_ber_cnt_inc == C_HIBER_THRESH) begin
        hi_ber_d = 1'b1;
      end
    end
  end

  assign o_hi_ber = hi_ber_q;
`else
  assign o_hi_ber = 1'b0;

  // The hi-BER parameters stay part of the interface in this build. This
  // empty block references them so that they count as used.
  if ((HIBER_TIMER_CYCLES == 0) || (HIBER_THRESH == 0)) begin : g_hiber_params_unused
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rx_block_lock.sv
`default_nettype none
// ============================================================================
// Module      : tb_rx_block_lock
// Description : Directed self-checking bench for rx_block_lock. It covers
//               lock acquisition, slip on a pre-lock error, locked error
//               tolerance, header qualification, reset and init-done
//               interruptions, and the hi-BER window when
//               RX_BLOCK_LOCK_HIBER_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_block_lock;

`ifdef RX_BLOCK_LOCK_HIBER_EN
  localparam logic C_HIBER_IDLE = 1'b1;
`else
  localparam logic C_HIBER_IDLE = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       r_init_done;
  logic [1:0] r_header;
  logic       r_data_valid;
  logic       r_header_valid;
  logic       w_block_lock;
  logic       w_slip;
  logic       w_hi_ber;

  int n_checks = 0;
  int n_pass   = 0;
  int n_slip_pulses = 0;
  int n_slip_consec = 0;
  logic r_prev_slip = 1'b0;

  rx_block_lock #(
    .SH_CNT_MAX         (64),
    .SH_INVALID_MAX     (16),
    .SLIP_WAIT          (32),
    .HIBER_TIMER_CYCLES (200),
    .HIBER_THRESH       (16)
  ) u_dut (
    .i_rxc             (clk),
    .i_reset_n         (rst_n),
    .i_init_done       (r_init_done),
    .i_rx_header       (r_header),
    .i_rx_data_valid   (r_data_valid),
    .i_rx_header_valid (r_header_valid),
    .o_block_lock      (w_block_lock),
    .o_slip            (w_slip),
    .o_hi_ber          (w_hi_ber)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Drives one word, then samples outputs 1 ns after the edge. The slip
  // pulse count and any back-to-back slips are tracked here.
  task automatic tick(input logic [1:0] h, input logic dv, input logic hv);
    r_header       = h;
    r_data_valid   = dv;
    r_header_valid = hv;
    @(posedge clk);
    #1;
    if (w_slip) n_slip_pulses++;
    if (w_slip && r_prev_slip) n_slip_consec++;
    r_prev_slip = w_slip;
  endtask

  task automatic send_n(input int n, input logic [1:0] h);
    for (int i = 0; i < n; i++) tick(h, 1'b1, 1'b1);
  endtask

  // Pulses reset, releases it on a falling edge, raises init_done, and
  // spends one idle cycle so that the DUT moves from INIT to TEST.
  task automatic reset_and_start();
    r_init_done    = 1'b0;
    r_data_valid   = 1'b0;
    r_header_valid = 1'b0;
    rst_n          = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n       = 1'b1;
    r_init_done = 1'b1;
    tick(2'b00, 1'b0, 1'b0);
    n_slip_pulses = 0;
    n_slip_consec = 0;
  endtask

  initial begin
    rst_n          = 1'b0;
    r_init_done    = 1'b0;
    r_header       = 2'b00;
    r_data_valid   = 1'b0;
    r_header_valid = 1'b0;
    #3;
    chk("reset_lock", w_block_lock, 0);
    chk("reset_slip", w_slip, 0);
    chk("reset_hiber", w_hi_ber, C_HIBER_IDLE);

    // 1. Lock acquisition
    reset_and_start();
    send_n(63, 2'b01);
    chk("t1_lock_after63", w_block_lock, 0);
    tick(2'b01, 1'b1, 1'b1);
    chk("t1_lock_after64", w_block_lock, 1);
    chk("t1_no_slip", n_slip_pulses, 0);
    chk("t1_hiber", w_hi_ber, C_HIBER_IDLE);

    // 2. Pre-lock error on header 10, then 32 discarded (invalid) headers
    reset_and_start();
    send_n(9, 2'b01);
    tick(2'b00, 1'b1, 1'b1);
    chk("t2_slip_not_yet", w_slip, 0);
    tick(2'b01, 1'b1, 1'b1);            // SLIP cycle, header ignored
    chk("t2_slip_pulse", w_slip, 1);
    chk("t2_lock_low", w_block_lock, 0);
    tick(2'b00, 1'b1, 1'b1);
    chk("t2_slip_single", w_slip, 0);
    send_n(31, 2'b00);
    send_n(63, 2'b01);
    chk("t2_lock_after63", w_block_lock, 0);
    tick(2'b01, 1'b1, 1'b1);
    chk("t2_lock_after64", w_block_lock, 1);
    chk("t2_one_slip", n_slip_pulses, 1);

    // 3. Locked tolerance: 15 bad headers held, 16 bad headers lose lock
    send_n(15, 2'b00);
    send_n(49, 2'b10);
    chk("t3_hold_15", w_block_lock, 1);
    chk("t3_no_slip_15", n_slip_pulses, 1);
    send_n(15, 2'b11);
    chk("t3_hold_w2_15", w_block_lock, 1);
    chk("t3_no_early_slip", n_slip_pulses, 1);
    tick(2'b00, 1'b1, 1'b1);
    chk("t3_16th_lock", w_block_lock, 1);
    chk("t3_16th_slip", w_slip, 0);
    tick(2'b01, 1'b1, 1'b1);
    chk("t3_slip_pulse", w_slip, 1);
    chk("t3_lock_lost", w_block_lock, 0);
    tick(2'b01, 1'b1, 1'b1);
    chk("t3_slip_single", w_slip, 0);
    chk("t3_no_consec", n_slip_consec, 0);

    // 4. Qualification: unqualified bad headers have no effect
    reset_and_start();
    send_n(30, 2'b01);
    tick(2'b11, 1'b0, 1'b1);
    tick(2'b00, 1'b1, 1'b0);
    send_n(33, 2'b01);
    chk("t4_lock_after63", w_block_lock, 0);
    tick(2'b01, 1'b1, 1'b1);
    chk("t4_lock_after64", w_block_lock, 1);
    chk("t4_no_slip", n_slip_pulses, 0);

    // 5. Asynchronous reset mid-window, then init_done drop
    send_n(20, 2'b01);
    chk("t5_locked", w_block_lock, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_lock", w_block_lock, 0);
    chk("t5_async_slip", w_slip, 0);
    chk("t5_async_hiber", w_hi_ber, C_HIBER_IDLE);
    reset_and_start();
    send_n(64, 2'b01);
    chk("t5_relock", w_block_lock, 1);
    r_init_done = 1'b0;
    tick(2'b00, 1'b1, 1'b1);
    chk("t5_init_drop_lock", w_block_lock, 0);
    chk("t5_init_drop_slip", w_slip, 0);
    tick(2'b00, 1'b1, 1'b1);
    chk("t5_init_hold_slip", w_slip, 0);
    r_init_done = 1'b1;
    tick(2'b00, 1'b0, 1'b0);
    send_n(63, 2'b01);
    chk("t5_lock_after63", w_block_lock, 0);
    tick(2'b01, 1'b1, 1'b1);
    chk("t5_lock_after64", w_block_lock, 1);
    chk("t5_no_slip", n_slip_pulses, 0);

`ifdef RX_BLOCK_LOCK_HIBER_EN
    // 6. Hi-BER with a 200-cycle window. Lock rises at E0. Windows end at
    //    E200/E400/E600. Errors at E201-208 and E257-264 fall in different
    //    64-header lock windows, 8 in each.
    reset_and_start();
    send_n(64, 2'b01);
    chk("t6_lock", w_block_lock, 1);
    chk("t6_hiber_initial", w_hi_ber, 1);
    for (int k = 1; k <= 600; k++) begin
      if ((k >= 201 && k <= 208) || (k >= 257 && k <= 264)) tick(2'b00, 1'b1, 1'b1);
      else tick(2'b01, 1'b1, 1'b1);
      if (k == 199) chk("t6_hiber_before_exp1", w_hi_ber, 1);
      if (k == 200) chk("t6_hiber_clear_exp1", w_hi_ber, 0);
      if (k == 263) chk("t6_hiber_15_errs", w_hi_ber, 0);
      if (k == 264) chk("t6_hiber_set_16", w_hi_ber, 1);
      if (k == 400) chk("t6_hiber_held_exp2", w_hi_ber, 1);
      if (k == 599) chk("t6_hiber_before_exp3", w_hi_ber, 1);
      if (k == 600) chk("t6_hiber_clear_exp3", w_hi_ber, 0);
    end
    chk("t6_lock_held", w_block_lock, 1);
    chk("t6_no_slip", n_slip_pulses, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
